// File: rtl/sr_arb_pkg.sv
// sr_arb_pkg: shared definitions for the SR lock arbiter.
//   state_t / IDLE, SET, HELD, CLEAR : arbiter FSM encoding
//   CONF_MAX_DEFAULT                 : default confirm budget in cycles
//   next_owner()                     : rotating-priority search, returns {valid, index}
package sr_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SET   = 2'd1;
   localparam state_t HELD  = 2'd2;
   localparam state_t CLEAR = 2'd3;

   localparam int unsigned CONF_MAX_DEFAULT = 4;
   localparam int unsigned MAX_REQ          = 16;

   // First asserted bit of req at or above ptr, wrapping at n_req-1.
   // Walking k downward lets the lowest rotated distance overwrite the result last.
   function automatic logic [4:0] next_owner(input logic [MAX_REQ-1:0] req,
                                             input logic [3:0]         ptr,
                                             input logic [4:0]         n_req);
      logic [4:0] res;
      logic [4:0] cand;
      res = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + 5'(k);
         if (cand >= n_req) cand = cand - n_req;
         if ((5'(k) < n_req) && req[cand[3:0]]) res = {1'b1, cand[3:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/SR_FF_async.sv
// SR_FF_async: SR lock flag flop, asynchronous active-high reset.
//   clk, reset : clock and reset
//   s, r       : set / clear commands (2'b11 holds the current value)
//   q          : flag state
module SR_FF_async (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic r,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else if (s && !r) begin
         q <= 1'b1;
      end else if (r && !s) begin
         q <= 1'b0;
      end
   end

endmodule

// File: rtl/sr_arb_rr_pick.sv
// sr_arb_rr_pick: combinational round-robin winner selection.
//   req    : per-requester request level
//   rr_ptr : index with highest priority this round
//   winner : selected requester index (meaningful only when valid)
//   valid  : at least one request is asserted
module sr_arb_rr_pick
   import sr_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   logic [MAX_REQ-1:0] req_ext;
   logic [4:0]         pick;

   always_comb begin
      req_ext = '0;
      req_ext[N_REQ-1:0] = req;
      pick = next_owner(req_ext, 4'(rr_ptr), 5'(N_REQ));
   end

   assign valid  = pick[4];
   assign winner = IDX_W'(pick[3:0]);

endmodule

// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter: round-robin arbiter owning a shared SR lock flag.
//   clk, reset  : clock, asynchronous active-high reset
//   req, rel    : per-requester request level / release (rel only honoured for the owner)
//   flag_q      : q of the external SR lock flop
//   s_out,r_out : set / clear commands to the flop, never both high
//   grant       : one-hot grant while the lock is held
//   owner       : current or last owner index
//   busy        : FSM not in IDLE
//   timeout_evt : one-cycle pulse when a hold is forcibly ended
//   err         : sticky confirm-timeout flag
module sr_lock_arbiter
   import sr_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned IDX_W    = $clog2(N_REQ),
   parameter int unsigned HOLD_MAX = 255,
   parameter int unsigned HOLD_W   = 8,
   parameter int unsigned CONF_MAX = CONF_MAX_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] rel,
   input  logic             flag_q,
   output logic             s_out,
   output logic             r_out,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] owner,
   output logic             busy,
   output logic             timeout_evt,
   output logic             err
);

   localparam int unsigned       CONF_W    = (CONF_MAX > 2) ? $clog2(CONF_MAX) : 1;
   localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_MAX - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [CONF_W-1:0]  conf_cnt_q, conf_cnt_d;
   logic               s_q, s_d, r_q, r_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               tevt_q, tevt_d;
   logic               err_q, err_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic [IDX_W-1:0]   rr_after;

   sr_arb_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // Priority moves just past whoever last held (or tried to take) the lock.
   assign rr_after = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      conf_cnt_d = conf_cnt_q;
      s_d        = s_q;
      r_d        = r_q;
      grant_d    = grant_q;
      tevt_d     = 1'b0;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d    = pick_idx;
               s_d        = 1'b1;
               conf_cnt_d = '0;
               state_d    = SET;
            end
         end
         SET: begin
            if (flag_q) begin
               s_d        = 1'b0;
               grant_d    = N_REQ'(1) << owner_q;
               hold_cnt_d = '0;
               state_d    = HELD;
            end else if (conf_cnt_q == CONF_LAST) begin
               // Flag never confirmed: back the flop out and never grant.
               err_d      = 1'b1;
               s_d        = 1'b0;
               r_d        = 1'b1;
               conf_cnt_d = '0;
               rr_ptr_d   = rr_after;
               state_d    = CLEAR;
            end else begin
               conf_cnt_d = conf_cnt_q + CONF_W'(1);
            end
         end
         HELD: begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (rel[owner_q] || (hold_cnt_q == HOLD_LAST)) begin
               grant_d    = '0;
               r_d        = 1'b1;
               conf_cnt_d = '0;
               rr_ptr_d   = rr_after;
               // A release on the timeout edge wins, so no timeout pulse.
               tevt_d     = !rel[owner_q];
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            if (!flag_q) begin
               r_d     = 1'b0;
               state_d = IDLE;
            end else if (conf_cnt_q == CONF_LAST) begin
               err_d   = 1'b1;
               r_d     = 1'b0;
               state_d = IDLE;
            end else begin
               conf_cnt_d = conf_cnt_q + CONF_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         conf_cnt_q <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         tevt_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         conf_cnt_q <= conf_cnt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         tevt_q     <= tevt_d;
         err_q      <= err_d;
      end
   end

   assign s_out       = s_q;
   assign r_out       = r_q;
   assign grant       = grant_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign timeout_evt = tevt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// tb_sr_lock_arbiter: scoreboard bench for sr_lock_arbiter with an SR_FF_async lock flop.
// Stimulus pushes expected output events (changes of grant/busy/err) with their cycle;
// a negedge monitor pops and compares them and checks the structural invariants.
module tb_sr_lock_arbiter;
   import sr_arb_pkg::*;

   typedef struct packed {
      logic [3:0]  grant;
      logic [1:0]  owner;
      logic        busy;
      logic        tevt;
      logic        err;
      logic [31:0] cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] rel = '0;
   logic       flag_q, ff_q, s_out, r_out, busy, timeout_evt, err;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       force_zero = 1'b0;
   logic       mon_en = 1'b0;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   s_cnt = 0, r_cnt = 0, tevt_cnt = 0, gnt_cnt = 0;
   ev_t  sb_q[$];

   assign flag_q = force_zero ? 1'b0 : ff_q;

   sr_lock_arbiter #(
      .N_REQ    (4),
      .IDX_W    (2),
      .HOLD_MAX (8),
      .HOLD_W   (8),
      .CONF_MAX (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .rel         (rel),
      .flag_q      (flag_q),
      .s_out       (s_out),
      .r_out       (r_out),
      .grant       (grant),
      .owner       (owner),
      .busy        (busy),
      .timeout_evt (timeout_evt),
      .err         (err)
   );

   SR_FF_async u_flop (
      .clk   (clk),
      .reset (reset),
      .s     (s_out),
      .r     (r_out),
      .q     (ff_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] o, input logic b,
                       input logic t, input logic e, input int c);
      ev_t ev;
      ev.grant = g; ev.owner = o; ev.busy = b; ev.tevt = t; ev.err = e; ev.cyc = 32'(c);
      sb_q.push_back(ev);
   endtask

   // Full transaction: request sampled at edge e, release/timeout at edge f.
   task automatic push_txn(input logic [1:0] w, input int e, input int f,
                           input logic t, input logic er);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      push(4'b0000, w, 1'b1, 1'b0, er, e);
      push(oh,      w, 1'b1, 1'b0, er, e + 2);
      push(4'b0000, w, 1'b1, t,    er, f);
      push(4'b0000, w, 1'b0, 1'b0, er, f + 2);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : monitor
      logic [5:0] prev, cur;
      ev_t        act, e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {grant, busy, err};
         if (mon_en) begin
            if (s_out) s_cnt++;
            if (r_out) r_cnt++;
            if (timeout_evt) tevt_cnt++;
            if (grant != 4'b0000) gnt_cnt++;
            checks++;
            if ((s_out && r_out) || !$onehot0(grant) ||
                ((grant != 4'b0000) && (dut.state_q != HELD)) ||
                (busy != (dut.state_q != IDLE))) begin
               failures++;
               $display("FAIL invariant cyc=%0d actual s=%b r=%b grant=%b busy=%b state=%0d",
                        cyc, s_out, r_out, grant, busy, dut.state_q);
            end
            if (cur !== prev) begin
               act.grant = grant; act.owner = owner; act.busy = busy;
               act.tevt = timeout_evt; act.err = err; act.cyc = 32'(cyc);
               checks++;
               if (sb_q.size() == 0) begin
                  failures++;
                  $display("FAIL sb_unexpected actual g=%b o=%0d b=%b t=%b e=%b cyc=%0d required none",
                           act.grant, act.owner, act.busy, act.tevt, act.err, act.cyc);
               end else begin
                  e = sb_q.pop_front();
                  if (act !== e) begin
                     failures++;
                     $display({"FAIL sb_event actual g=%b o=%0d b=%b t=%b e=%b cyc=%0d",
                               " required g=%b o=%0d b=%b t=%b e=%b cyc=%0d"},
                              act.grant, act.owner, act.busy, act.tevt, act.err, act.cyc,
                              e.grant, e.owner, e.busy, e.tevt, e.err, e.cyc);
                  end
               end
            end
         end
         prev = cur;
      end
   end

   initial begin : watchdog
      #200000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stim
      int e, f, e2, f2;
      logic [1:0] w;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_s_r", 32'({s_out, r_out}), 0);
      chk("rst_tevt_err", 32'({timeout_evt, err}), 0);
      chk("rst_flop_q", 32'(ff_q), 0);
      mon_en = 1'b1;

      // Round-robin with all requesting, each owner releasing after 3 held cycles.
      req = 4'b1111;
      e = cyc + 1;
      for (int i = 0; i < 5; i++) begin
         w = 2'(i % 4);
         f = e + 5;
         push_txn(w, e, f, 1'b0, 1'b0);
         wait_cyc(e + 4);
         rel = 4'b0001 << w;
         wait_cyc(f);
         rel = '0;
         if (i == 4) req = '0;
         e = f + 3;
      end
      wait_cyc(e);

      // Single grant to requester 2.
      s_cnt = 0; r_cnt = 0;
      req = 4'b0100;
      e = cyc + 1;
      push_txn(2'd2, e, e + 4, 1'b0, 1'b0);
      wait_cyc(e + 2);
      req = '0;
      wait_cyc(e + 3);
      rel = 4'b0100;
      wait_cyc(e + 4);
      rel = '0;
      chk("single_r_out", 32'(r_out), 1);
      chk("single_flop_still_set", 32'(ff_q), 1);
      wait_cyc(e + 6);
      chk("single_flop_cleared", 32'(ff_q), 0);
      chk("single_s_cycles", 32'(s_cnt), 2);
      chk("single_r_cycles", 32'(r_cnt), 2);

      // Foreign release is ignored.
      req = 4'b0010;
      e = cyc + 1;
      push_txn(2'd1, e, e + 6, 1'b0, 1'b0);
      wait_cyc(e + 2);
      req = '0;
      rel = 4'b0001;
      wait_cyc(e + 3);
      rel = '0;
      wait_cyc(e + 5);
      chk("foreign_grant", 32'(grant), 32'h2);
      chk("foreign_flag", 32'(ff_q), 1);
      rel = 4'b0010;
      wait_cyc(e + 6);
      rel = '0;
      wait_cyc(e + 8);

      // Hold timeout for owner 2, then requester 1 is next.
      tevt_cnt = 0;
      req = 4'b0110;
      e = cyc + 1;
      f = e + 10;
      push_txn(2'd2, e, f, 1'b1, 1'b0);
      e2 = f + 3;
      f2 = e2 + 3;
      push_txn(2'd1, e2, f2, 1'b0, 1'b0);
      wait_cyc(e2 + 2);
      req = '0;
      rel = 4'b0010;
      wait_cyc(f2);
      rel = '0;
      wait_cyc(f2 + 2);
      chk("timeout_pulse_count", 32'(tevt_cnt), 1);

      // Confirm failure: flag never rises.
      force_zero = 1'b1;
      s_cnt = 0; r_cnt = 0; gnt_cnt = 0;
      req = 4'b0001;
      e = cyc + 1;
      push(4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, e);
      push(4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, e + 4);
      push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, e + 5);
      wait_cyc(e);
      req = '0;
      wait_cyc(e + 7);
      chk("conf_s_cycles", 32'(s_cnt), 4);
      chk("conf_r_cycles", 32'(r_cnt), 1);
      chk("conf_no_grant", 32'(gnt_cnt), 0);
      force_zero = 1'b0;

      // Asynchronous reset while owner 2 holds the lock.
      req = 4'b0100;
      e = cyc + 1;
      push(4'b0000, 2'd2, 1'b1, 1'b0, 1'b1, e);
      push(4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, e + 2);
      wait_cyc(e + 2);
      req = '0;
      wait_cyc(e + 4);
      reset = 1'b1;
      #1;
      chk("arst_grant", 32'(grant), 0);
      chk("arst_s_r", 32'({s_out, r_out}), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_flop_q", 32'(ff_q), 0);
      push(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, cyc);
      #1 reset = 1'b0;

      // Pointer restarted at 0: requester 0 beats requester 2.
      req = 4'b0101;
      e = cyc + 1;
      push_txn(2'd0, e, e + 4, 1'b0, 1'b0);
      wait_cyc(e + 2);
      req = '0;
      wait_cyc(e + 3);
      rel = 4'b0001;
      wait_cyc(e + 4);
      rel = '0;
      wait_cyc(e + 6);

      req = 4'b1000;
      e = cyc + 1;
      push_txn(2'd3, e, e + 4, 1'b0, 1'b0);
      wait_cyc(e + 2);
      req = '0;
      wait_cyc(e + 3);
      rel = 4'b1000;
      wait_cyc(e + 4);
      rel = '0;
      wait_cyc(e + 8);

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
